// File: rtl/wb_dec_pkg.sv
// Shared types and helpers for the user-area Wishbone decoder.
package wb_dec_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_e;

  localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;
  localparam int          MAX_SLV      = 8;

  typedef struct packed {
    logic       hit;
    logic [2:0] idx;
  } match_t;

  // Prefix match over up to MAX_SLV table bytes; lowest matching index wins.
  function automatic match_t prefix_match(input logic [7:0]           pfx,
                                          input logic [MAX_SLV*8-1:0] base,
                                          input int                   num);
    match_t m;
    m = '0;
    for (int i = MAX_SLV - 1; i >= 0; i--) begin
      if (i < num && base[i*8 +: 8] == pfx) begin
        m.hit = 1'b1;
        m.idx = 3'(i);
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/wb_user_decoder_if.sv
// Wishbone master-to-decoder bus (mgmt SoC side).
interface wb_user_decoder_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_adr_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    output wbs_ack_o, wbs_dat_o
  );

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    input  wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/wb_dec_timer.sv
// Saturating bus-timeout counter. tc is raised in the cycle whose increment
// brings the count to TIMEOUT, so the caller can react on that same edge.
module wb_dec_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT);
  localparam logic [W-1:0] LAST  = W'(TIMEOUT - 1);

  logic [W-1:0] cnt;

  // Count while enabled, hold at LIMIT, never wrap.
  always_ff @(posedge clk) begin
    if (rst || clr)              cnt <= '0;
    else if (en && cnt != LIMIT) cnt <= cnt + 1'b1;
  end

  assign tc = en && (cnt == LAST || cnt == LIMIT);
endmodule

// File: rtl/wb_user_decoder.sv
// Wishbone decoder/mux for the user project area: routes the mgmt master to
// NUM_SLV slaves by adr[31:24], registers the return path, answers unmapped
// addresses itself and aborts hung slaves after TIMEOUT cycles.
// Optional build macro WB_DEC_STATUS_EN adds an internal status register at
// prefix STATUS_BASE (timeout count and last timed-out slave index).
module wb_user_decoder
  import wb_dec_pkg::*;
#(
  parameter int                   NUM_SLV     = 4,
  // byte i (LSB byte = slave 0): slave 0 = 0x38, 1 = 0x30, 2 = 0x31, 3 = 0x32
  parameter logic [NUM_SLV*8-1:0] BASE_VEC    = {8'h32, 8'h31, 8'h30, 8'h38},
  parameter int                   TIMEOUT     = 255,
  parameter logic [31:0]          ERR_DATA    = ERR_DATA_DEF,
  parameter logic [7:0]           STATUS_BASE = 8'h3F
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  wb_user_decoder_if.slave       wbs,
  output logic [NUM_SLV-1:0]     slv_stb_o,
  input  logic [NUM_SLV-1:0]     slv_ack_i,
  input  logic [NUM_SLV*32-1:0]  slv_dat_i,
  output logic                   err_o
);
  localparam int IW = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

  state_e                    state;
  logic [IW-1:0]             sel_q;
  logic                      dflt_q;
  logic                      req;
  logic                      tc;
  match_t                    m;
  logic [NUM_SLV-1:0][31:0]  sdat;

  assign sdat = slv_dat_i;
  assign req  = wbs.wbs_cyc_i & wbs.wbs_stb_i;
  assign m    = prefix_match(wbs.wbs_adr_i[31:24], (MAX_SLV*8)'(BASE_VEC), NUM_SLV);

  // Write data, byte selects and low address bits only matter to the slaves.
  logic unused_bus;
  assign unused_bus = ^{wbs.wbs_sel_i, wbs.wbs_dat_i, wbs.wbs_adr_i[23:0], wbs.wbs_we_i};

  wb_dec_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk (wb_clk_i),
    .rst (wb_rst_i),
    .clr (state != BUSY),
    .en  (state == BUSY && !dflt_q),
    .tc  (tc)
  );

`ifdef WB_DEC_STATUS_EN
  logic        sta_hit;
  logic [15:0] to_cnt;
  logic [2:0]  last_idx;
  assign sta_hit = (wbs.wbs_adr_i[31:24] == STATUS_BASE);
`else
  logic [7:0] unused_status;
  assign unused_status = STATUS_BASE;
`endif

  // Transfer FSM with registered strobe, ack, data and error outputs.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state         <= IDLE;
      wbs.wbs_ack_o <= 1'b0;
      wbs.wbs_dat_o <= '0;
      slv_stb_o     <= '0;
      err_o         <= 1'b0;
      sel_q         <= '0;
      dflt_q        <= 1'b0;
`ifdef WB_DEC_STATUS_EN
      to_cnt        <= '0;
      last_idx      <= '0;
`endif
    end else begin
      wbs.wbs_ack_o <= 1'b0;
      err_o         <= 1'b0;
      case (state)
        IDLE: if (req) begin
`ifdef WB_DEC_STATUS_EN
          if (sta_hit) begin
            state         <= ACK;
            wbs.wbs_ack_o <= 1'b1;
            if (wbs.wbs_we_i) begin
              to_cnt   <= '0;
              last_idx <= '0;
            end else begin
              wbs.wbs_dat_o <= {to_cnt, 5'b0, last_idx, 8'b0};
            end
          end else begin
`else
          begin
`endif
            sel_q  <= IW'(m.idx);
            dflt_q <= !m.hit;
            state  <= BUSY;
            for (int i = 0; i < NUM_SLV; i++)
              slv_stb_o[i] <= m.hit && (m.idx == 3'(i));
          end
        end
        BUSY: begin
          if (!wbs.wbs_cyc_i) begin
            state     <= IDLE;
            slv_stb_o <= '0;
          end else if (dflt_q) begin
            wbs.wbs_dat_o <= '0;
            wbs.wbs_ack_o <= 1'b1;
            state         <= ACK;
          end else if (slv_ack_i[sel_q]) begin
            wbs.wbs_dat_o <= sdat[sel_q];
            wbs.wbs_ack_o <= 1'b1;
            slv_stb_o     <= '0;
            state         <= ACK;
          end else if (tc) begin
            wbs.wbs_dat_o <= ERR_DATA;
            wbs.wbs_ack_o <= 1'b1;
            err_o         <= 1'b1;
            slv_stb_o     <= '0;
            state         <= ACK;
`ifdef WB_DEC_STATUS_EN
            if (to_cnt != 16'hFFFF) to_cnt <= to_cnt + 1'b1;
            last_idx <= 3'(sel_q);
`endif
          end
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_user_decoder.sv
// Bench for wb_user_decoder: DUT0 uses the default map with TIMEOUT=255,
// DUT1 uses an overlapping map with TIMEOUT=4 for priority/coincidence cases.
module tb_wb_user_decoder;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  wb_user_decoder_if bus0();
  wb_user_decoder_if bus1();

  logic        m_cyc[2], m_stb[2], m_we[2];
  logic [3:0]  m_sel[2];
  logic [31:0] m_dat[2], m_adr[2];
  logic        m_ack[2];
  logic [31:0] m_rdat[2];
  logic [3:0]  stb_o[2], ack_i[2];
  logic [127:0] dat_i[2];
  logic        err[2];

  assign bus0.wbs_cyc_i = m_cyc[0];  assign bus1.wbs_cyc_i = m_cyc[1];
  assign bus0.wbs_stb_i = m_stb[0];  assign bus1.wbs_stb_i = m_stb[1];
  assign bus0.wbs_we_i  = m_we[0];   assign bus1.wbs_we_i  = m_we[1];
  assign bus0.wbs_sel_i = m_sel[0];  assign bus1.wbs_sel_i = m_sel[1];
  assign bus0.wbs_dat_i = m_dat[0];  assign bus1.wbs_dat_i = m_dat[1];
  assign bus0.wbs_adr_i = m_adr[0];  assign bus1.wbs_adr_i = m_adr[1];
  assign m_ack[0]  = bus0.wbs_ack_o; assign m_ack[1]  = bus1.wbs_ack_o;
  assign m_rdat[0] = bus0.wbs_dat_o; assign m_rdat[1] = bus1.wbs_dat_o;

  wb_user_decoder #(.NUM_SLV(4), .BASE_VEC(32'h3231_3038), .TIMEOUT(255),
                    .ERR_DATA(32'hDEAD_BEEF), .STATUS_BASE(8'h3F)) u_dut0 (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs(bus0.slave), .slv_stb_o(stb_o[0]),
    .slv_ack_i(ack_i[0]), .slv_dat_i(dat_i[0]), .err_o(err[0]));

  wb_user_decoder #(.NUM_SLV(4), .BASE_VEC(32'h4041_4042), .TIMEOUT(4),
                    .ERR_DATA(32'h0BAD_F00D), .STATUS_BASE(8'h3F)) u_dut1 (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs(bus1.slave), .slv_stb_o(stb_o[1]),
    .slv_ack_i(ack_i[1]), .slv_dat_i(dat_i[1]), .err_o(err[1]));

  // Reference address map, timeout and error word per DUT.
  logic [7:0]  base_t[2][4] = '{'{8'h38, 8'h30, 8'h31, 8'h32}, '{8'h42, 8'h40, 8'h41, 8'h40}};
  int          tmo_t[2]     = '{255, 4};
  logic [31:0] errd_t[2]    = '{32'hDEAD_BEEF, 32'h0BAD_F00D};
  logic [31:0] sdata[2][4];

  int n_cmp = 0;
  int n_bad = 0;

  function automatic int target(input int d, input logic [31:0] adr);
    for (int i = 0; i < 4; i++) if (base_t[d][i] == adr[31:24]) return i;
    return -1;
  endfunction

  task automatic set_slv_data(input int d);
    for (int i = 0; i < 4; i++) sdata[d][i] = $urandom;
    dat_i[d] = {sdata[d][3], sdata[d][2], sdata[d][1], sdata[d][0]};
  endtask

  // One master transfer; cycle 0 is the request cycle. The selected slave
  // acks in its dly-th strobe cycle (dly=0: never); other slaves ack randomly.
  task automatic xfer(input int d, input logic [31:0] adr, input logic we, input int dly,
                      output int ack_cyc, output logic [31:0] rd, output int err_cnt,
                      output int stb_cnt, output logic [3:0] stb_or, output int multi);
    logic [3:0] s, noise;
    @(negedge clk);
    m_adr[d] = adr; m_we[d] = we; m_dat[d] = $urandom; m_sel[d] = 4'hF;
    m_cyc[d] = 1'b1; m_stb[d] = 1'b1;
    ack_cyc = -1; rd = '0; err_cnt = 0; stb_cnt = 0; stb_or = '0; multi = 0;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      s = stb_o[d];
      if (err[d]) err_cnt++;
      if (s != 4'b0) begin
        stb_cnt++;
        stb_or |= s;
        if ($countones(s) != 1) multi++;
      end
      noise = 4'($urandom_range(0, 15)) & ~s;
      if ($urandom_range(0, 3) != 0) noise = 4'b0;
      ack_i[d] = noise;
      if (s != 4'b0 && dly > 0 && stb_cnt == dly) ack_i[d] = noise | s;
      if (m_ack[d]) begin
        ack_cyc = c; rd = m_rdat[d];
        m_cyc[d] = 1'b0; m_stb[d] = 1'b0; ack_i[d] = 4'b0;
        break;
      end
    end
    if (ack_cyc < 0) begin
      m_cyc[d] = 1'b0; m_stb[d] = 1'b0; ack_i[d] = 4'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      m_cyc[d] = 1'b1; m_stb[d] = 1'b1; m_adr[d] = 32'h3800_0000; ack_i[d] = 4'hF;
    end
    repeat (4) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (m_ack[d] !== 1'b0 || m_rdat[d] !== 32'h0 || stb_o[d] !== 4'h0 || err[d] !== 1'b0) begin
        n_bad++;
        $display("FAIL reset[%0d]: ack=%b dat=%h stb=%b err=%b want all 0", d, m_ack[d], m_rdat[d], stb_o[d], err[d]);
      end
      m_cyc[d] = 1'b0; m_stb[d] = 1'b0; ack_i[d] = 4'h0;
    end
    rst = 1'b0;
  endtask

  task automatic test_read_slave0();
    int a, e, sc, mu; logic [31:0] rd; logic [3:0] so;
    set_slv_data(0);
    sdata[0][0] = 32'h1234_5678;
    dat_i[0][31:0] = 32'h1234_5678;
    xfer(0, 32'h3800_0010, 1'b0, 3, a, rd, e, sc, so, mu);
    n_cmp++;
    if (a !== 4 || rd !== 32'h1234_5678 || sc !== 3 || so !== 4'b0001 || e !== 0 || mu !== 0) begin
      n_bad++;
      $display("FAIL rd_slv0: ack@%0d dat=%h stbc=%0d stb=%b err=%0d multi=%0d want ack@4 12345678 3 0001 0 0", a, rd, sc, so, e, mu);
    end
  endtask

  task automatic test_write_slave2();
    int a, e, sc, mu; logic [31:0] rd; logic [3:0] so;
    set_slv_data(0);
    xfer(0, 32'h3100_0004, 1'b1, 1, a, rd, e, sc, so, mu);
    n_cmp++;
    if (a !== 2 || rd !== sdata[0][2] || sc !== 1 || so !== 4'b0100 || e !== 0 || mu !== 0) begin
      n_bad++;
      $display("FAIL wr_slv2: ack@%0d dat=%h stbc=%0d stb=%b err=%0d want ack@2 %h 1 0100 0", a, rd, sc, so, e, sdata[0][2]);
    end
  endtask

  task automatic test_unmapped();
    int a, e, sc, mu; logic [31:0] rd; logic [3:0] so;
    logic [31:0] adrs[3] = '{32'h5000_0000, 32'h3F00_0000, 32'h0000_0000};
    for (int k = 0; k < 3; k++) begin
      set_slv_data(0);
      xfer(0, adrs[k], k[0], 1, a, rd, e, sc, so, mu);
      n_cmp++;
      if (a !== 2 || rd !== 32'h0 || so !== 4'b0 || e !== 0) begin
        n_bad++;
        $display("FAIL unmapped %h: ack@%0d dat=%h stb=%b err=%0d want ack@2 0 0000 0", adrs[k], a, rd, so, e);
      end
    end
  endtask

  task automatic test_timeout();
    int a, e, sc, mu; logic [31:0] rd; logic [3:0] so;
    set_slv_data(0);
    xfer(0, 32'h3200_0000, 1'b0, 0, a, rd, e, sc, so, mu);
    n_cmp++;
    if (a !== 256 || rd !== 32'hDEAD_BEEF || e !== 1 || sc !== 255 || so !== 4'b1000) begin
      n_bad++;
      $display("FAIL timeout: ack@%0d dat=%h err=%0d stbc=%0d stb=%b want ack@256 deadbeef 1 255 1000", a, rd, e, sc, so);
    end
    @(negedge clk);
    n_cmp++;
    if (m_ack[0] !== 1'b0 || err[0] !== 1'b0 || m_rdat[0] !== 32'hDEAD_BEEF) begin
      n_bad++;
      $display("FAIL to_hold: ack=%b err=%b dat=%h want 0 0 deadbeef", m_ack[0], err[0], m_rdat[0]);
    end
  endtask

  task automatic test_abort();
    int bad, a, e, sc, mu; logic [31:0] rd; logic [3:0] so;
    for (int pass = 0; pass < 2; pass++) begin
      @(negedge clk);
      m_adr[0] = (pass == 0) ? 32'h3000_0000 : 32'h3100_0000; m_we[0] = 1'b0;
      m_cyc[0] = 1'b1; m_stb[0] = 1'b1; ack_i[0] = 4'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (stb_o[0] !== ((pass == 0) ? 4'b0010 : 4'b0100)) begin
        n_bad++;
        $display("FAIL abort_stb[%0d]: stb=%b want %b", pass, stb_o[0], (pass == 0) ? 4'b0010 : 4'b0100);
      end
      m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
      if (pass == 1) rst = 1'b1;
      bad = 0;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        rst = 1'b0;
        if (m_ack[0] !== 1'b0 || stb_o[0] !== 4'b0 || err[0] !== 1'b0) bad++;
      end
      n_cmp++;
      if (bad !== 0) begin
        n_bad++;
        $display("FAIL abort[%0d]: %0d cycles with ack/stb/err active want 0", pass, bad);
      end
    end
    set_slv_data(0);
    xfer(0, 32'h3800_0000, 1'b0, 2, a, rd, e, sc, so, mu);
    n_cmp++;
    if (a !== 3 || rd !== sdata[0][0] || e !== 0 || so !== 4'b0001) begin
      n_bad++;
      $display("FAIL after_abort: ack@%0d dat=%h err=%0d stb=%b want ack@3 %h 0 0001", a, rd, e, so, sdata[0][0]);
    end
  endtask

  task automatic test_coincide();
    int a, e, sc, mu; logic [31:0] rd; logic [3:0] so;
    set_slv_data(1);
    xfer(1, 32'h4100_0000, 1'b0, 4, a, rd, e, sc, so, mu);
    n_cmp++;
    if (a !== 5 || rd !== sdata[1][2] || e !== 0 || so !== 4'b0100) begin
      n_bad++;
      $display("FAIL coincide: ack@%0d dat=%h err=%0d stb=%b want ack@5 %h 0 0100", a, rd, e, so, sdata[1][2]);
    end
    set_slv_data(1);
    xfer(1, 32'h4100_0000, 1'b0, 5, a, rd, e, sc, so, mu);
    n_cmp++;
    if (a !== 5 || rd !== 32'h0BAD_F00D || e !== 1 || sc !== 4) begin
      n_bad++;
      $display("FAIL late_ack: ack@%0d dat=%h err=%0d stbc=%0d want ack@5 0badf00d 1 4", a, rd, e, sc);
    end
  endtask

  task automatic test_priority();
    int a, e, sc, mu; logic [31:0] rd; logic [3:0] so;
    set_slv_data(1);
    xfer(1, 32'h4000_1234, 1'b0, 2, a, rd, e, sc, so, mu);
    n_cmp++;
    if (a !== 3 || rd !== sdata[1][1] || so !== 4'b0010 || mu !== 0) begin
      n_bad++;
      $display("FAIL priority: ack@%0d dat=%h stb=%b want ack@3 %h 0010", a, rd, so, sdata[1][1]);
    end
  endtask

  task automatic test_random();
    int d, t, dly, a, e, sc, mu, ea, ee, esc; logic [31:0] adr, rd, ed; logic [7:0] pfx; logic [3:0] so, eso;
    for (int n = 0; n < 60; n++) begin
      d = $urandom_range(0, 1);
      t = $urandom_range(0, 5);
      pfx = (t < 4) ? base_t[d][t] : (t == 4) ? 8'h3F : 8'($urandom);
      adr = {pfx, 24'($urandom)};
      dly = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 7);
      set_slv_data(d);
      xfer(d, adr, 1'($urandom), dly, a, rd, e, sc, so, mu);
      t = target(d, adr);
      if (t < 0) begin
        ea = 2; ed = 32'h0; ee = 0; esc = 0; eso = 4'b0;
      end else if (dly >= 1 && dly <= tmo_t[d]) begin
        ea = dly + 1; ed = sdata[d][t]; ee = 0; esc = dly; eso = 4'(1 << t);
      end else begin
        ea = tmo_t[d] + 1; ed = errd_t[d]; ee = 1; esc = tmo_t[d]; eso = 4'(1 << t);
      end
      n_cmp++;
      if (a !== ea || rd !== ed || e !== ee || sc !== esc || so !== eso || mu !== 0) begin
        n_bad++;
        $display("FAIL rand[%0d] d%0d adr=%h dly=%0d: ack@%0d dat=%h err=%0d stbc=%0d stb=%b want ack@%0d %h %0d %0d %b",
                 n, d, adr, dly, a, rd, e, sc, so, ea, ed, ee, esc, eso);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      m_cyc[d] = 1'b0; m_stb[d] = 1'b0; m_we[d] = 1'b0; m_sel[d] = 4'h0;
      m_dat[d] = '0; m_adr[d] = '0; ack_i[d] = '0; dat_i[d] = '0;
    end
    test_reset();
    test_read_slave0();
    test_write_slave2();
    test_unmapped();
    test_timeout();
    test_abort();
    test_coincide();
    test_priority();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
